// File: rtl/tile_scheduler_if.sv
// tile_scheduler_if
//   Groups the job-request, TPU tile handshake and tile-descriptor signals
//   of the tile scheduler.
//   Job side   : start, m, k, n (host -> scheduler), busy, done, err (back)
//   TPU side   : tile_start, tile_row, tile_col, rows_valid, cols_valid,
//                a_base, b_base, o_base (scheduler -> TPU), tile_done (back)
//   Modports   : slave  - the scheduler itself
//                master - the host/TPU environment driving it
interface tile_scheduler_if;
  logic       start;
  logic [4:0] m;
  logic [4:0] k;
  logic [4:0] n;
  logic       tile_done;
  logic       tile_start;
  logic [2:0] tile_row;
  logic [2:0] tile_col;
  logic [2:0] rows_valid;
  logic [2:0] cols_valid;
  logic [7:0] a_base;
  logic [7:0] b_base;
  logic [7:0] o_base;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  start, m, k, n, tile_done,
    output tile_start, tile_row, tile_col, rows_valid, cols_valid,
           a_base, b_base, o_base, busy, done, err
  );

  modport master (
    output start, m, k, n, tile_done,
    input  tile_start, tile_row, tile_col, rows_valid, cols_valid,
           a_base, b_base, o_base, busy, done, err
  );
endinterface

// File: rtl/tile_scheduler.sv
// tile_scheduler
//   Walks the 4x4 output tiles of an (m x k) * (k x n) matrix job in
//   row-major order, launching one tile at a time on the TPU and waiting
//   for its write-back before moving on. Jobs with any zero dimension
//   finish immediately with err.
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (state to IDLE, outputs to 0)
//   bus   : tile_scheduler_if.slave (job request, tile handshake,
//           tile indices, valid row/col counts, buffer base indices,
//           busy/done/err status)
module tile_scheduler (
  input  logic               clk,
  input  logic               rst_n,
  tile_scheduler_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    NEXT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [4:0] m_q;
  logic [4:0] k_q;
  logic [4:0] n_q;
  logic [3:0] tm_q;
  logic [3:0] tn_q;
  logic [2:0] row_q;
  logic [2:0] col_q;
  logic       err_q;

  logic       dim_zero;
  logic       last_col;
  logic       last_tile;
  logic [5:0] tile_idx;

  // Number of 4-wide tiles needed to cover a dimension: ceil(d/4), 1..8.
  function automatic logic [3:0] ceil_tiles(input logic [4:0] d);
    logic [5:0] s;
    s = {1'b0, d} + 6'd3;
    return s[5:2];
  endfunction

  // Rows/cols left in the tile starting at 4*idx, saturated to 0..4.
  // The lower clamp only matters in the CALC cycle, when the indices
  // still hold the previous job's values.
  function automatic logic [2:0] sat_valid(input logic [4:0] dim,
                                           input logic [2:0] idx);
    logic signed [6:0] rem;
    rem = $signed({2'b00, dim}) - $signed({2'b00, idx, 2'b00});
    if (rem > 7'sd4)
      return 3'd4;
    else if (rem < 7'sd0)
      return 3'd0;
    else
      return rem[2:0];
  endfunction

  assign dim_zero  = (m_q == 5'd0) || (k_q == 5'd0) || (n_q == 5'd0);
  assign last_col  = ({1'b0, col_q} == (tn_q - 4'd1));
  assign last_tile = ({1'b0, row_q} == (tm_q - 4'd1)) && last_col;

  // ---- control state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.tile_start = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start)
          state_nxt = CALC;
      end
      CALC: begin
        bus.busy  = 1'b1;
        state_nxt = dim_zero ? FIN : ISSUE;
      end
      ISSUE: begin
        bus.busy       = 1'b1;
        bus.tile_start = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        bus.busy = 1'b1;
        if (bus.tile_done)
          state_nxt = NEXT;
      end
      NEXT: begin
        bus.busy  = 1'b1;
        state_nxt = last_tile ? FIN : ISSUE;
      end
      FIN: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        bus.err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- job dimensions and tile walk ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= 5'd0;
      k_q   <= 5'd0;
      n_q   <= 5'd0;
      tm_q  <= 4'd0;
      tn_q  <= 4'd0;
      row_q <= 3'd0;
      col_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_q <= bus.m;
            k_q <= bus.k;
            n_q <= bus.n;
          end
        end
        CALC: begin
          tm_q  <= ceil_tiles(m_q);
          tn_q  <= ceil_tiles(n_q);
          row_q <= 3'd0;
          col_q <= 3'd0;
          err_q <= dim_zero;
        end
        NEXT: begin
          if (!last_tile) begin
            if (last_col) begin
              col_q <= 3'd0;
              row_q <= row_q + 3'd1;
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---- tile descriptor ----
  // Largest values: 7*31 = 217 for a/b, (7*8+7)*4 = 252 for o.
  assign tile_idx       = ({3'b000, row_q} * {2'b00, tn_q}) + {3'b000, col_q};
  assign bus.tile_row   = row_q;
  assign bus.tile_col   = col_q;
  assign bus.a_base     = {5'd0, row_q} * {3'd0, k_q};
  assign bus.b_base     = {5'd0, col_q} * {3'd0, k_q};
  assign bus.o_base     = {tile_idx, 2'b00};
  assign bus.rows_valid = sat_valid(m_q, row_q);
  assign bus.cols_valid = sat_valid(n_q, col_q);

endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler
//   Directed and randomized jobs for tile_scheduler, checked cycle by cycle
//   against expectations computed from the tiling rules (tile counts,
//   row-major order, base indices, valid counts, latencies).
module tb_tile_scheduler;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   ts_count = 0;
  int   done_count = 0;

  tile_scheduler_if bus ();

  tile_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tile_start === 1'b1) ts_count++;
    if (bus.done === 1'b1) done_count++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " tile_start"}, bus.tile_start, 0);
    chk({tag, " busy"},       bus.busy, 0);
    chk({tag, " done"},       bus.done, 0);
    chk({tag, " err"},        bus.err, 0);
    chk({tag, " tile_row"},   bus.tile_row, 0);
    chk({tag, " tile_col"},   bus.tile_col, 0);
    chk({tag, " a_base"},     bus.a_base, 0);
    chk({tag, " b_base"},     bus.b_base, 0);
    chk({tag, " o_base"},     bus.o_base, 0);
    chk({tag, " rows_valid"}, bus.rows_valid, 0);
    chk({tag, " cols_valid"}, bus.cols_valid, 0);
  endtask

  // Runs one job. fixed_d >= 0 sets the extra WAIT cycles before tile_done
  // (otherwise random 0..3). abort_at >= 0 returns while in the first WAIT
  // cycle of that tile index. noise adds ignored start/tile_done pulses.
  task automatic run_job(input int mm, input int kk, input int nn,
                         input int fixed_d, input int abort_at,
                         input bit noise);
    int tm, tn, rv, cv, d, ts_base;
    bit illegal;
    tm = (mm + 3) / 4;
    tn = (nn + 3) / 4;
    illegal = (mm == 0) || (kk == 0) || (nn == 0);
    ts_base = ts_count;

    chk("idle busy", bus.busy, 0);
    bus.m = 5'(mm);
    bus.k = 5'(kk);
    bus.n = 5'(nn);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("calc busy", bus.busy, 1);
    chk("calc tile_start", bus.tile_start, 0);
    chk("calc done", bus.done, 0);

    if (illegal) begin
      step();
      chk("err done", bus.done, 1);
      chk("err err", bus.err, 1);
      chk("err busy", bus.busy, 1);
      chk("err tile_start", bus.tile_start, 0);
      step();
      chk("err idle busy", bus.busy, 0);
      chk("err idle done", bus.done, 0);
      chk("err idle err", bus.err, 0);
      chk("err tile_start count", ts_count - ts_base, 0);
      return;
    end

    for (int r = 0; r < tm; r++) begin
      for (int c = 0; c < tn; c++) begin
        rv = (mm - 4 * r < 4) ? (mm - 4 * r) : 4;
        cv = (nn - 4 * c < 4) ? (nn - 4 * c) : 4;
        step();
        chk("issue tile_start", bus.tile_start, 1);
        chk("issue busy", bus.busy, 1);
        chk("issue done", bus.done, 0);
        chk("issue err", bus.err, 0);
        chk("tile_row", bus.tile_row, r);
        chk("tile_col", bus.tile_col, c);
        chk("a_base", bus.a_base, r * kk);
        chk("b_base", bus.b_base, c * kk);
        chk("o_base", bus.o_base, (r * tn + c) * 4);
        chk("rows_valid", bus.rows_valid, rv);
        chk("cols_valid", bus.cols_valid, cv);
        if (noise) bus.tile_done = 1'b1;
        step();
        bus.tile_done = 1'b0;
        if (r * tn + c == abort_at) return;
        chk("wait tile_start", bus.tile_start, 0);
        chk("wait busy", bus.busy, 1);
        d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 3));
        for (int j = 0; j < d; j++) begin
          if (noise && ($urandom_range(0, 1) == 1)) bus.start = 1'b1;
          step();
          bus.start = 1'b0;
          chk("wait hold tile_start", bus.tile_start, 0);
          chk("wait hold done", bus.done, 0);
          chk("wait hold row", bus.tile_row, r);
          chk("wait hold col", bus.tile_col, c);
          chk("wait hold a_base", bus.a_base, r * kk);
        end
        bus.tile_done = 1'b1;
        step();
        bus.tile_done = 1'b0;
        chk("next tile_start", bus.tile_start, 0);
        chk("next done", bus.done, 0);
      end
    end
    step();
    chk("fin done", bus.done, 1);
    chk("fin err", bus.err, 0);
    chk("fin busy", bus.busy, 1);
    chk("fin tile_start", bus.tile_start, 0);
    step();
    chk("idle after fin busy", bus.busy, 0);
    chk("idle after fin done", bus.done, 0);
    chk("tile_start count", ts_count - ts_base, tm * tn);
  endtask

  initial begin
    int mm, kk, nn, dc;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.tile_done = 1'b0;
    bus.m = 5'd0;
    bus.k = 5'd0;
    bus.n = 5'd0;
    step();
    step();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // tile_done while idle changes nothing
    bus.tile_done = 1'b1;
    step();
    bus.tile_done = 1'b0;
    chk("idle tile_done busy", bus.busy, 0);
    chk("idle tile_done tile_start", bus.tile_start, 0);
    chk("idle tile_done done", bus.done, 0);
    chk("idle tile_done row", bus.tile_row, 0);

    // start @0, tile_start @2, tile_done @5, done @7
    run_job(4, 4, 4, 2, -1, 1'b0);
    run_job(5, 3, 9, -1, -1, 1'b1);
    run_job(31, 31, 31, -1, -1, 1'b0);
    run_job(4, 0, 4, -1, -1, 1'b0);
    run_job(0, 5, 5, -1, -1, 1'b0);

    repeat (8) begin
      mm = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
      kk = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
      nn = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
      run_job(mm, kk, nn, -1, -1, 1'($urandom_range(0, 1)));
    end

    // reset during WAIT of the third tile (row 1, col 0) of an 8x8x8 job
    run_job(8, 8, 8, 1, 2, 1'b0);
    chk("pre-reset tile_row", bus.tile_row, 1);
    chk("pre-reset busy", bus.busy, 1);
    dc = done_count;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    step();
    chk("reset held busy", bus.busy, 0);
    chk("reset held done", bus.done, 0);
    rst_n = 1'b1;
    run_job(4, 4, 4, 2, -1, 1'b0);
    chk("aborted job done count", done_count - dc, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
TILE_SCHEDULER -- requirements
Module: tile_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle request to run one matrix job; sampled only in IDLE.
REQ-004 SHALL have ports: m, k, n  input  5 each  job dimensions (A is m x k, B is k x n), latched on accepted start.
REQ-005 SHALL have port: tile_done  input  1  one-cycle pulse from the TPU; the current tile has been written back.
REQ-006 SHALL have port: tile_start  output  1  one-cycle pulse that launches one 4x4 output tile on the TPU.
REQ-007 SHALL have ports: tile_row, tile_col  output  3 each  output-tile indices, stable from tile_start until the next tile_start.
REQ-008 SHALL have ports: rows_valid, cols_valid  output  3 each  valid rows/cols in the current tile, range 1..4.
REQ-009 SHALL have ports: a_base, b_base, o_base  output  8 each  global-buffer word base indices for the current tile.
REQ-010 SHALL have ports: busy  output  1  high from the cycle after start is accepted until done; done  output  1  one-cycle job-complete pulse; err  output  1  high together with done for an illegal job.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, ISSUE, WAIT, NEXT, FIN.
REQ-012 SHALL transition IDLE->CALC on start, latching m, k, n; start in any other state SHALL be ignored.
REQ-013 SHALL, in CALC, compute tm = (m+3)>>2 and tn = (n+3)>>2, clear tile_row/tile_col to 0, then go to FIN with err=1 if m, k or n is 0, else to ISSUE.
REQ-014 SHALL assert tile_start for exactly the one ISSUE cycle, then go to WAIT unconditionally.
REQ-015 SHALL stay in WAIT until tile_done=1, then go to NEXT; tile_done in any state other than WAIT SHALL be ignored.
REQ-016 SHALL, in NEXT, go to FIN if tile_row==tm-1 and tile_col==tn-1; otherwise it SHALL go to ISSUE after advancing in row-major order: tile_col+1, wrapping to 0 at tn and incrementing tile_row.
REQ-017 SHALL, in FIN, pulse done for one cycle (err as decided in CALC) and return to IDLE; busy SHALL be high in CALC through FIN excluding nothing else.
REQ-018 SHALL drive a_base = tile_row*k, b_base = tile_col*k and o_base = (tile_row*tn + tile_col)*4; maxima of 217, 217 and 252 fit in 8 bits without wrap.
REQ-019 SHALL drive rows_valid = min(4, m-4*tile_row) and cols_valid = min(4, n-4*tile_col).
REQ-020 SHALL have the following latency: start accepted in cycle t gives tile_start at t+2; tile_done at cycle u gives the next tile_start at u+2, or done at u+2 for the last tile.
REQ-021 SHALL complete an err job with start at t and done+err at t+2, with no tile_start.
REQ-022 SHALL accept a new start in the IDLE cycle immediately following FIN.

Reset
REQ-023 SHALL, while rst_n=0 and regardless of state, force the state to IDLE and all outputs to 0 immediately; latched dimensions SHALL clear to 0.
REQ-024 SHALL, when reset occurs mid-job, discard the job with no done pulse, and the first cycle after release SHALL accept start.

Verification
REQ-025 SHALL cover: m=k=n=4, start @0 -> tile_start @2 with row0 col0, bases 0/0/0, valid 4/4; tile_done @5 -> done @7, err=0.
REQ-026 SHALL cover: m=5, k=3, n=9 -> 6 tiles in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); the last tile has a_base=3, b_base=6, o_base=20, rows_valid=1, cols_valid=1.
REQ-027 SHALL cover: m=31, k=31, n=31 -> 64 tile_starts; the last tile has a_base=217, b_base=217, o_base=252, rows_valid=3, cols_valid=3.
REQ-028 SHALL cover: k=0 -> done=1, err=1 @2, no tile_start, busy high only in cycles 1-2.
REQ-029 SHALL cover: start pulsed in WAIT, and tile_done pulsed in ISSUE and in IDLE -> no state, index or output change.
REQ-030 SHALL cover: rst_n low for 1 cycle during WAIT of tile 3 -> outputs are 0 at once, no done pulse, and a new job with m=k=n=4 started after release completes per REQ-025.
